// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side consumer.
// Holds the FSM state encoding, default sizing and the landing-buffer depth rule.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_TOTAL  = 256;
    localparam int DEF_RD_LAT = 1;

    // One slot per cycle of FIFO read latency plus one for the word being offered.
    function automatic int land_depth(input int rd_lat);
        return rd_lat + 1;
    endfunction

endpackage

// File: rtl/rd_land_buf.sv
// Circular landing buffer that absorbs words arriving after the FIFO read latency.
// Push writes the tail, pop retires the head; occupancy is tracked explicitly.
module rd_land_buf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [OW-1:0]    occ_q, occ_d;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push) begin
            mem_d[tail_q] = push_data;
            tail_d        = next_ptr(tail_q);
        end
        if (pop) begin
            head_d = next_ptr(head_q);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head_data = mem_q[head_q];
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_rd_stage.sv
// Read-domain consumer of the dual-clock FIFO: pops, lands, and delivers TOTAL-word frames.
// Build option FIFO_RD_ZERO_OUT_EN forces out_data to zero whenever out_valid is low.
module fifo_rd_stage
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int TOTAL  = DEF_TOTAL,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_rempty,
    output logic             fifo_rinc,
    input  logic [WIDTH-1:0] fifo_rdata,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             frame_done,
    output logic             busy,
    output rd_state_e        dbg_state
);

    localparam int DEPTH = land_depth(RD_LAT);
    localparam int OW    = $clog2(DEPTH+1);
    localparam int CW    = $clog2(TOTAL+1);

    // Handshake: a word transfers on every cycle where out_valid and out_ready are both
    // high; once out_valid rises, out_valid and out_data hold until that transfer happens.

    rd_state_e         state_q, state_d;
    logic [CW-1:0]     issued_q, issued_d;
    logic [CW-1:0]     delivered_q, delivered_d;
    logic [RD_LAT-1:0] sr_q, sr_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;

    logic [OW-1:0]     occ;
    logic [OW-1:0]     inflight;
    logic [WIDTH-1:0]  head_data;
    logic              land;
    logic              pop_out;
    int                level;

    assign land      = sr_q[RD_LAT-1];
    assign out_valid = (occ != '0);
    assign pop_out   = out_valid & out_ready;

    // Occupancy the buffer will have once this cycle's delivery retires, counting words in flight.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + OW'(sr_q[i]);
        end
        level     = int'(occ) + int'(inflight) - (pop_out ? 1 : 0);
        fifo_rinc = (state_q == ST_RUN) && !fifo_rempty && (level < DEPTH);
        sr_d      = (sr_q << 1) | RD_LAT'(fifo_rinc);
    end

    always_comb begin
        state_d      = state_q;
        issued_d     = issued_q;
        delivered_d  = delivered_q;
        frame_done_d = 1'b0;
        if (fifo_rinc) begin
            issued_d = issued_q + 1'b1;
        end
        if (pop_out) begin
            delivered_d = delivered_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (!fifo_rempty) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fifo_rinc && (issued_q == CW'(TOTAL-1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop_out && (delivered_q == CW'(TOTAL-1))) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                    issued_d     = '0;
                    delivered_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            issued_q     <= '0;
            delivered_q  <= '0;
            sr_q         <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            delivered_q  <= delivered_d;
            sr_q         <= sr_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    rd_land_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_land_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (land),
        .push_data (fifo_rdata),
        .pop       (pop_out),
        .head_data (head_data),
        .occ       (occ)
    );

`ifdef FIFO_RD_ZERO_OUT_EN
    assign out_data = out_valid ? head_data : '0;
`else
    assign out_data = head_data;
`endif

    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule
